// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Responder end of the cache-to-memory interface. Serialises instruction-cache
// and data-cache accesses onto a single-ported RAM. Data requests win over
// instruction requests unless the fairness mode is compiled in.
//
// Optional feature macro: ARB_FAIR_EN
//   When defined, a last-grant bit alternates priority under contention:
//   after a data completion, a simultaneous instruction request wins the next
//   arbitration. Aborts leave the bit untouched.
//
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   iREN, iaddr          instruction read request / word address
//   iwait, iload         low for the completing cycle / read data in that cycle
//   dREN, dWEN           data read / write request (write wins if both high)
//   daddr, dstore        data address / write data
//   dwait, dload         low for the completing cycle / read data in that cycle
//   ramREN, ramWEN       RAM read / write enable (registered)
//   ramaddr, ramstore    RAM address / write data (registered)
//   ramload, ramready    RAM read data / access-complete strobe
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // instruction cache side
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    // data cache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } state_t;

    state_t state;

    logic dreq;
    logic inst_first;
    logic dcomplete;
    logic icomplete;

    assign dreq = dREN | dWEN;

`ifdef ARB_FAIR_EN
    // Set by a data completion, cleared by an instruction completion.
    logic last_grant;
    assign inst_first = iREN & last_grant;
`else
    assign inst_first = 1'b0;
`endif

    // Completion is combinational from state and ramready so the cache sees
    // it with no added latency. Gating with nRST keeps a reset that lands on
    // the ramready cycle from leaking a completion pulse.
    assign dcomplete = nRST & (state == DGNT) & ramready;
    assign icomplete = nRST & (state == IGNT) & ramready;

    assign dwait = ~dcomplete;
    assign iwait = ~icomplete;

    // ramWEN still holds the latched access type throughout the grant.
    assign dload = (dcomplete && !ramWEN) ? ramload : '0;
    assign iload = icomplete ? ramload : '0;

    // The RAM-side registers double as the request latches: they are loaded
    // on grant and held until completion or abort, so requester changes
    // during a grant never reach the RAM.
    // NOTE: all state here is assigned with non-blocking (<=) so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
`ifdef ARB_FAIR_EN
            last_grant <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && !inst_first) begin
                        state    <= DGNT;
                        ramWEN   <= dWEN;
                        ramREN   <= ~dWEN;
                        ramaddr  <= daddr;
                        ramstore <= dWEN ? dstore : '0;
                    end else if (iREN) begin
                        state    <= IGNT;
                        ramREN   <= 1'b1;
                        ramWEN   <= 1'b0;
                        ramaddr  <= iaddr;
                        ramstore <= '0;
                    end
                end

                DGNT: begin
                    // Completion takes precedence over a same-cycle enable drop.
                    if (ramready || !dreq) begin
                        state    <= IDLE;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                    end
`ifdef ARB_FAIR_EN
                    if (ramready) begin
                        last_grant <= 1'b1;
                    end
`endif
                end

                IGNT: begin
                    if (ramready || !iREN) begin
                        state    <= IDLE;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                    end
`ifdef ARB_FAIR_EN
                    if (ramready) begin
                        last_grant <= 1'b0;
                    end
`endif
                end

                default: begin
                    state    <= IDLE;
                    ramREN   <= 1'b0;
                    ramWEN   <= 1'b0;
                    ramaddr  <= '0;
                    ramstore <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Directed testbench for cache_mem_arbiter. The bench plays the RAM itself,
// driving ramready/ramload on chosen cycles, and compares every output against
// hand-computed values. Inputs change 1 ns after the rising edge; outputs are
// sampled 1 ns later, well away from the clock edge.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    int n_checks = 0;
    int n_fail   = 0;

    cache_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        nRST = 1'b1;
        settle();
        chk("rst_iwait",    iwait,    1);
        chk("rst_dwait",    dwait,    1);
        chk("rst_iload",    iload,    0);
        chk("rst_dload",    dload,    0);
        chk("rst_ramREN",   ramREN,   0);
        chk("rst_ramWEN",   ramWEN,   0);
        chk("rst_ramaddr",  ramaddr,  0);
        chk("rst_ramstore", ramstore, 0);

        // ---------------- data write, address changes mid-grant ----------------
        dWEN   = 1'b1;
        daddr  = 32'h200;
        dstore = 32'h1234_5678;
        tick();                                   // DGNT
        daddr  = 32'h300;
        dstore = 32'hFFFF_0000;
        settle();
        chk("wr_ramWEN",   ramWEN,   1);
        chk("wr_ramREN",   ramREN,   0);
        chk("wr_ramaddr",  ramaddr,  32'h200);
        chk("wr_ramstore", ramstore, 32'h1234_5678);
        chk("wr_dwait_pre", dwait,   1);
        tick();                                   // still DGNT
        chk("wr_ramaddr_hold", ramaddr, 32'h200);
        ramready = 1'b1;
        ramload  = 32'hAAAA_5555;
        settle();
        chk("wr_dwait_done", dwait, 0);
        chk("wr_dload_zero", dload, 0);
        chk("wr_iwait",      iwait, 1);
        tick();                                   // IDLE bubble
        ramready = 1'b0;
        dWEN     = 1'b0;
        settle();
        chk("wr_bubble_ramWEN", ramWEN, 0);
        chk("wr_bubble_dwait",  dwait,  1);

        // ---------------- instruction read, 3-cycle RAM ----------------
        iREN  = 1'b1;
        iaddr = 32'h100;
        tick();                                   // IGNT cycle 1
        chk("ird_c1_ramREN",  ramREN,  1);
        chk("ird_c1_ramaddr", ramaddr, 32'h100);
        chk("ird_c1_iwait",   iwait,   1);
        tick();                                   // IGNT cycle 2
        chk("ird_c2_ramREN",  ramREN,  1);
        chk("ird_c2_iwait",   iwait,   1);
        tick();                                   // IGNT cycle 3, RAM ready
        ramready = 1'b1;
        ramload  = 32'hDEAD_BEEF;
        settle();
        chk("ird_c3_ramaddr", ramaddr, 32'h100);
        chk("ird_iwait_done", iwait,   0);
        chk("ird_iload",      iload,   32'hDEAD_BEEF);
        chk("ird_dload_idle", dload,   0);
        tick();                                   // IDLE
        ramready = 1'b0;
        iREN     = 1'b0;
        settle();
        chk("ird_idle_ramREN", ramREN, 0);
        chk("ird_idle_iwait",  iwait,  1);
        chk("ird_idle_iload",  iload,  0);

        // ---------------- simultaneous requests: data first ----------------
        iREN  = 1'b1;
        iaddr = 32'h80;
        dREN  = 1'b1;
        daddr = 32'h40;
        tick();                                   // DGNT
        chk("sim_d_ramaddr", ramaddr, 32'h40);
        chk("sim_d_ramREN",  ramREN,  1);
        ramready = 1'b1;
        ramload  = 32'h0000_0011;
        settle();
        chk("sim_d_dwait", dwait, 0);
        chk("sim_d_dload", dload, 32'h11);
        chk("sim_d_iwait", iwait, 1);
        chk("sim_d_iload", iload, 0);
        tick();                                   // bubble
        ramready = 1'b0;
        dREN     = 1'b0;
        settle();
        chk("sim_bubble_ramREN", ramREN, 0);
        chk("sim_bubble_iwait",  iwait,  1);
        tick();                                   // IGNT
        chk("sim_i_ramaddr", ramaddr, 32'h80);
        ramready = 1'b1;
        ramload  = 32'h0000_0022;
        settle();
        chk("sim_i_iwait", iwait, 0);
        chk("sim_i_iload", iload, 32'h22);
        tick();
        ramready = 1'b0;
        iREN     = 1'b0;

        // ---------------- data read alone, then contention again ----------------
        dREN  = 1'b1;
        daddr = 32'h50;
        tick();                                   // DGNT
        ramready = 1'b1;
        ramload  = 32'h0000_0033;
        settle();
        chk("drd_dload", dload, 32'h33);
        tick();
        ramready = 1'b0;
        dREN     = 1'b0;
        tick();                                   // IDLE
        iREN  = 1'b1;
        iaddr = 32'h90;
        dREN  = 1'b1;
        daddr = 32'h60;
        tick();                                   // contention grant
        ramready = 1'b1;
        ramload  = 32'h0000_0044;
        settle();
`ifdef ARB_FAIR_EN
        chk("fair_ramaddr",  ramaddr,        32'h90);
        chk("fair_waits",    {iwait, dwait}, 2'b01);
`else
        chk("strict_ramaddr", ramaddr,        32'h60);
        chk("strict_waits",   {iwait, dwait}, 2'b10);
`endif
        tick();
        ramready = 1'b0;
        iREN     = 1'b0;
        dREN     = 1'b0;
        tick();

        // ---------------- abort during DGNT ----------------
        dREN  = 1'b1;
        daddr = 32'h70;
        tick();                                   // DGNT
        chk("abt_ramREN", ramREN, 1);
        chk("abt_dwait1", dwait,  1);
        dREN = 1'b0;
        settle();
        chk("abt_dwait2", dwait, 1);
        tick();                                   // IDLE
        chk("abt_ramREN_off", ramREN,  0);
        chk("abt_ramaddr",    ramaddr, 0);
        chk("abt_dwait3",     dwait,   1);
        tick();
        chk("abt_stay_idle",  ramREN,  0);

        // ---------------- reset during IGNT with ramready ----------------
        iREN  = 1'b1;
        iaddr = 32'h120;
        tick();                                   // IGNT
        chk("rsti_ramREN", ramREN, 1);
        nRST     = 1'b0;
        ramready = 1'b1;
        ramload  = 32'h0000_0055;
        settle();
        chk("rsti_no_iwait_pulse", iwait, 1);
        chk("rsti_no_iload",       iload, 0);
        tick();
        chk("rsti_ramREN_after",  ramREN,  0);
        chk("rsti_ramaddr_after", ramaddr, 0);
        chk("rsti_iwait_after",   iwait,   1);
        nRST     = 1'b1;
        ramready = 1'b0;
        iREN     = 1'b0;
        tick();

        // ---------------- dREN and dWEN together: write ----------------
        dREN   = 1'b1;
        dWEN   = 1'b1;
        daddr  = 32'h210;
        dstore = 32'h0000_0055;
        tick();                                   // DGNT
        chk("both_ramWEN",   ramWEN,   1);
        chk("both_ramREN",   ramREN,   0);
        chk("both_ramstore", ramstore, 32'h55);
        ramready = 1'b1;
        ramload  = 32'h0000_0066;
        settle();
        chk("both_dwait", dwait, 0);
        chk("both_dload", dload, 0);
        tick();
        ramready = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        tick();

        // ---------------- ramready in IDLE is ignored ----------------
        ramready = 1'b1;
        ramload  = 32'h0000_0077;
        settle();
        chk("idle_rdy_iwait", iwait, 1);
        chk("idle_rdy_dwait", dwait, 1);
        chk("idle_rdy_dload", dload, 0);
        tick();
        chk("idle_rdy_ramREN", ramREN, 0);
        ramready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Responder end of the cache-to-memory interface: services instruction-cache and data-cache miss/writeback requests and serialises them onto a single-ported RAM.
- Sits between the caches block and the RAM model/controller.
- Drives iwait/dwait back to the caches and returns read data on iload/dload.
- Fixed priority: data over instruction, with an optional fairness mode.

Parameters:
ADDR_W, 32, width of iaddr/daddr/ramaddr
DATA_W, 32, width of store/load data words

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
iREN  in  1  instruction read request
iaddr  in  ADDR_W  instruction word address
iwait  out  1  low for exactly the cycle an instruction read completes
iload  out  DATA_W  instruction read data, valid when iwait low
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
dwait  out  1  low for exactly the cycle a data access completes
dload  out  DATA_W  data read data, valid when dwait low on a read
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid with ramready
ramready  in  1  RAM completes the current access this cycle

Behaviour:
- Clock and reset: single clock CLK; nRST synchronous, active-low, sampled on the rising edge.
- State machine: IDLE, DGNT, IGNT.
- Reset, including mid-access:
  - state=IDLE; request latches cleared.
  - iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Any in-flight access is dropped; no completion is signalled.
- IDLE:
  - RAM enables 0; iwait=dwait=1.
  - If dREN|dWEN: latch daddr, dstore and type, go to DGNT.
  - Else if iREN: latch iaddr, go to IGNT.
  - Else stay.
- Access type:
  - dWEN has precedence over dREN when both are high; treat as a write.
- DGNT:
  - ramaddr=latched addr; ramWEN=latched write; ramREN=latched read; ramstore=latched data on writes, 0 on reads.
  - On ramready: dwait=0 that cycle; dload=ramload on reads, 0 on writes; next state IDLE.
- IGNT:
  - ramREN=1, ramaddr=latched iaddr.
  - On ramready: iwait=0 that cycle; iload=ramload; next state IDLE.
- Output timing:
  - wait/load outputs are combinational from state and ramready; zero added latency beyond RAM latency.
  - RAM outputs come from latched values; requester address/data changes during a grant are ignored.
- Abort:
  - If the granted requester's enable drops (dREN|dWEN=0 in DGNT, or iREN=0 in IGNT) before ramready, return to IDLE next cycle.
  - No completion is signalled; RAM enables deassert from that next cycle.
- Bubble:
  - One mandatory IDLE cycle after every completion or abort.
  - Each cache observes its wait high for at least one cycle between completions.
- Simultaneous requests in IDLE:
  - Data wins; instruction stays pending with iwait=1.
- Ungranted requester always sees wait=1 and load=0.
- ramready while in IDLE is ignored.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A 1-bit last-grant register is set on data completion and cleared on instruction completion; it resets to 0.
  - In IDLE with both requests pending and last-grant=1, the instruction side wins.
  - Aborts do not update last-grant.
- Undefined:
  - Strict data-over-instruction priority; instruction side may starve under continuous data traffic.

Test Plan:
- Reset then iREN=1, iaddr=0x100; RAM returns ramready after 3 cycles with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 3 cycles; iwait=0 and iload=0xDEADBEEF in the ready cycle only; IDLE next cycle.
- dWEN=1, daddr=0x200, dstore=0x12345678; daddr changes to 0x300 mid-grant -> ramWEN=1, ramaddr stays 0x200, ramstore=0x12345678; dwait=0 and dload=0 on ramready.
- iREN and dREN asserted together, both held -> data access completes first; one bubble; then instruction grant. With ARB_FAIR_EN and repeated dREN, the next simultaneous contention goes to instruction.
- dREN=1 then dropped after 1 cycle of DGNT with no ramready -> IDLE next cycle, ramREN=0, dwait stays 1 throughout.
- nRST=0 during IGNT with ramready arriving the same cycle -> all outputs at reset values next cycle; no iwait low pulse.
- dREN=dWEN=1 simultaneously -> ramWEN=1, ramREN=0 (write precedence).
